operand_sel_reg: RTL

//   Parametrised N-way operand selector with a latched select and a registered, handshaked output.

---
 rtl/dp_pkg.sv | 17 +
 rtl/mux_n.sv | 19 +
 rtl/operand_sel_reg.sv | 76 +++++++
 3 files changed

// File: rtl/dp_pkg.sv
// Shared datapath constants for the multicycle core operand selectors.
// Source select encodings match the control FSM's phase tables.
package dp_pkg;

    localparam int DP_WIDTH = 8;

    localparam int SEL_REG    = 0;
    localparam int SEL_CONST4 = 1;
    localparam int SEL_IMM    = 2;
    localparam int SEL_PC     = 3;

    // True when a select value addresses no physical input.
    function automatic logic sel_out_of_range(input int unsigned sel, input int unsigned n);
        return (sel >= n);
    endfunction

endpackage

// File: rtl/mux_n.sv
// Combinational WIDTH x NUM_IN selector; an out-of-range select yields all-zeros.
module mux_n #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    localparam int SEL_W = $clog2(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data
);

    always_comb begin
        out_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) out_data = in_data[k*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/operand_sel_reg.sv
// N-way operand selector with latched select and a registered valid/ready output stage.
// Build option OPERAND_SEL_ERR_EN makes sel_err a sticky illegal-select flag; otherwise sel_err is 0.
module operand_sel_reg
    import dp_pkg::*;
#(
    parameter int WIDTH  = DP_WIDTH,
    parameter int NUM_IN = 4,
    localparam int SEL_W = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sel_load,
    input  logic [SEL_W-1:0]        sel_in,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        sel_q,
    output logic                    sel_err
);

    logic [SEL_W-1:0] sel_eff;
    logic [WIDTH-1:0] mux_out;
    logic             capture;
    logic             drain;

    // Write-through: a select loaded this cycle already steers this cycle's capture.
    assign sel_eff  = sel_load ? sel_in : sel_q;
    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready;
    assign drain    = out_valid && out_ready && !capture;

    mux_n #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_mux (
        .in_data  (in_data),
        .sel      (sel_eff),
        .out_data (mux_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (sel_load) sel_q <= sel_in;
            if (capture) begin
                out_data  <= mux_out;
                out_valid <= 1'b1;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef OPERAND_SEL_ERR_EN
    logic sel_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_err_q <= 1'b0;
        end else if (capture && sel_out_of_range(32'(sel_eff), NUM_IN)) begin
            sel_err_q <= 1'b1;
        end
    end

    assign sel_err = sel_err_q;
`else
    assign sel_err = 1'b0;
`endif

endmodule
